simple_uart_rx: RTL
===================

Name: simple_uart_rx

Overview:
Serial receiver that consumes the `line` output of the team's simpleUARTtx transmitter, or an external RX pin. It recovers 8N1 frames: 1 start bit, 8 data bits LSB first, 1 stop bit, idle high. It presents each received byte on a parallel bus with a one-cycle valid strobe. It is the downstream partner of the transmitter and is used for loopback benches and host links.

Parameters:
CLKS_PER_BIT, 16, clk cycles per bit; must equal the transmitter's divisor; legal range >= 4.
HALF_BIT, CLKS_PER_BIT/2 (floor), derived localparam, not overridable; offset to bit centre.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
line  in  1  asynchronous serial input, idle high
data  out  8  last correctly received byte
valid  out  1  one-cycle pulse: `data` was just updated
ferr  out  1  one-cycle pulse: stop bit sampled low; frame discarded
busy  out  1  high from start-bit detection until return to IDLE

Behaviour:
- Single clock `clk`. Reset is synchronous and active-high (`rst`); it takes priority over all other logic.
- Reset values: data=8'h00, valid=0, ferr=0, busy=0, state=IDLE, synchronizer flops=1.
- Input path: `line` passes through 2 flops giving `line_s`. All decisions use `line_s` only, which adds 2 cycles of latency.
- States: IDLE, START, DATA, STOP, BREAK.
- IDLE:
  - On a cycle with line_s=0, go to START, clear the bit counter, load the baud counter, set busy=1.
  - Call this detection edge d.
- START:
  - Wait HALF_BIT cycles.
  - Sample line_s at edge d+HALF_BIT.
  - If 1: false start; go to IDLE, busy=0, no strobes.
  - If 0: go to DATA.
- DATA:
  - Sample at each CLKS_PER_BIT interval: edges d+HALF_BIT+k*CLKS_PER_BIT, for k=1..8.
  - Shift into an internal shift register, LSB first.
  - After the 8th sample, go to STOP.
- STOP:
  - Sample at edge d+HALF_BIT+9*CLKS_PER_BIT.
  - If 1: data <= shift register; valid=1 for exactly that one cycle; go to IDLE; busy=0 in the same cycle.
  - If 0: ferr=1 for one cycle; data holds its previous value; go to BREAK.
- BREAK: remain until line_s=1, then go to IDLE. A held-low line produces exactly one ferr pulse, not repeated errors.
- Back-to-back frames:
  - Return to IDLE happens at the mid-stop sample.
  - A start edge arriving immediately after the stop bit is detected normally.
  - No idle gap is required.
- valid and ferr are never high simultaneously. Both are registered outputs.
- Reset mid-frame: abort immediately, apply reset values, discard the partial byte. The next frame after rst deasserts is received normally.
- Counters: baud counter width $clog2(CLKS_PER_BIT); bit counter width 4. No wrap beyond 8 data bits.

Decomposition:
- Package simple_uart_pkg contains:
  - state enum (IDLE, START, DATA, STOP, BREAK)
  - localparam DATA_BITS=8
  - shared default CLKS_PER_BIT=16, reused by the transmitter bench.
- One sub-module, uart_rx_sync: 2-flop synchronizer with reset-to-1 and output line_s.
- The FSM, counters and shift register stay in simple_uart_rx.

Test Plan:
1. Loopback: simpleUARTtx `line` drives `line`, both with CLKS_PER_BIT=16. Send data=8'h01 -> one valid pulse with data=8'h01, ferr never set, busy low afterwards.
2. Back-to-back: the bench drives 8'hA5, then 8'h5A with no idle gap. Required response:
   - exactly 2 valid pulses, data=8'hA5 then 8'h5A;
   - pulses 10*16 cycles apart, within ±1 cycle.
3. Glitch: line low for 5 clk (less than HALF_BIT=8), then high -> busy pulses, returns to IDLE, no valid, no ferr, data unchanged.
4. Framing error: a frame of 8'h3C with the stop bit driven 0, then line held low for 40 bit times, then released. Required response:
   - exactly 1 ferr pulse;
   - no valid;
   - data keeps its prior value;
   - a following good 8'hC3 frame is received correctly.
5. Reset mid-frame: assert rst for 1 cycle during data bit 4 of 8'hFF. Required response:
   - outputs at reset values next cycle;
   - no valid for the aborted frame;
   - the next frame 8'h81 yields valid with data=8'h81.
6. Latency check: measure from the input falling edge of the start bit to valid. The result must be 2+HALF_BIT+9*CLKS_PER_BIT+1 cycles (=155 for 16), within ±1 cycle.

Source files
------------

// File: rtl/simple_uart_pkg.sv
// Shared definitions for the simple UART receiver and its transmitter partner.
//   DATA_BITS            : payload bits per 8N1 frame
//   DEFAULT_CLKS_PER_BIT : default baud divisor, shared with the transmitter bench
//   rx_state_e           : receiver FSM states
package simple_uart_pkg;

    localparam int DATA_BITS            = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer that brings the asynchronous serial line into the clk domain.
//   clk    in  : system clock, rising edge
//   rst    in  : synchronous reset, active-high
//   line   in  : asynchronous serial input, idle high
//   line_s out : synchronized copy of line, two cycles late
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic line,
    output logic line_s
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = line;
        sync_d = meta_q;
    end

    // NOTE: both flops reset to 1 (the idle level) so that leaving reset
    // never looks like a start-bit edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign line_s = sync_q;

endmodule

// File: rtl/simple_uart_rx.sv
// 8N1 serial receiver: 1 start bit, 8 data bits LSB first, 1 stop bit, idle high.
//   clk   in  : system clock, rising edge
//   rst   in  : synchronous reset, active-high, overrides everything
//   line  in  : asynchronous serial input, idle high
//   data  out : last correctly received byte
//   valid out : one-cycle pulse, data was just updated
//   ferr  out : one-cycle pulse, stop bit sampled low and frame discarded
//   busy  out : high from start-bit detection until the FSM is back in IDLE
module simple_uart_rx
    import simple_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       line,
    output logic [7:0] data,
    output logic       valid,
    output logic       ferr,
    output logic       busy
);

    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam int CNT_W    = $clog2(CLKS_PER_BIT);

    typedef logic [CNT_W-1:0] cnt_t;

    // The counter is loaded with N-1 and the sample is taken on the edge where it reads zero,
    // so that sample lands exactly N edges after the load.
    localparam cnt_t HALF_LOAD = cnt_t'(HALF_BIT - 1);
    localparam cnt_t FULL_LOAD = cnt_t'(CLKS_PER_BIT - 1);

    logic line_s;

    uart_rx_sync u_sync (
        .clk    (clk),
        .rst    (rst),
        .line   (line),
        .line_s (line_s)
    );

    rx_state_e  state_q, state_d;
    cnt_t       baud_q,  baud_d;
    logic [3:0] bit_q,   bit_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] data_q,  data_d;
    logic       valid_q, valid_d;
    logic       ferr_q,  ferr_d;
    logic       busy_q,  busy_d;

    logic tick;
    assign tick = (baud_q == '0);

    // State register and all other flops.
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // sees the pre-edge value of every other flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state logic, including the baud/bit counters and the shift register.
    // NOTE: every signal gets a hold default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;

        unique case (state_q)
            ST_IDLE: begin
                if (!line_s) begin
                    state_d = ST_START;
                    baud_d  = HALF_LOAD;
                    bit_d   = '0;
                end
            end
            ST_START: begin
                if (tick) begin
                    // A start bit that is high again at its centre was a glitch.
                    if (line_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DATA;
                        baud_d  = FULL_LOAD;
                    end
                end else begin
                    baud_d = baud_q - cnt_t'(1);
                end
            end
            ST_DATA: begin
                if (tick) begin
                    shift_d = {line_s, shift_q[7:1]};
                    bit_d   = bit_q + 4'd1;
                    baud_d  = FULL_LOAD;
                    if (bit_q == 4'(DATA_BITS - 1)) begin
                        state_d = ST_STOP;
                    end
                end else begin
                    baud_d = baud_q - cnt_t'(1);
                end
            end
            ST_STOP: begin
                // Leaving at mid-stop gives half a bit of slack to catch a
                // start edge that follows the stop bit with no idle gap.
                if (tick) begin
                    state_d = line_s ? ST_IDLE : ST_BREAK;
                end else begin
                    baud_d = baud_q - cnt_t'(1);
                end
            end
            ST_BREAK: begin
                // Wait for the line to recover so a held-low line yields one error only.
                if (line_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output logic, registered above so valid/ferr/busy are glitch-free.
    always_comb begin
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        busy_d  = (state_d != ST_IDLE);

        if (state_q == ST_STOP && tick) begin
            if (line_s) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                ferr_d = 1'b1;
            end
        end
    end

    assign data  = data_q;
    assign valid = valid_q;
    assign ferr  = ferr_q;
    assign busy  = busy_q;

endmodule
